board_engine: RTL and testbench

- Parametrised playfield engine for the Tetris core, generalising the fixed-size stacked-block register.
- Owns the stacked-block occupancy map and answers collision queries for the controlling piece's four cells.
- Commits (locks) a piece into the map, then performs sequential multi-row line clearing, line counting and game-over detection.
- Sits between the piece controller (which drives the candidate cells from ctrl_block) and the VGA renderer / score display.

---
 rtl/board_engine.sv | 161 ++++++++++++++++
 tb/tb_board_engine.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/board_engine.sv
// board_engine: playfield occupancy map for the Tetris core.
// Answers 4-cell collision queries, locks pieces into the map, then walks
// the rows bottom-up to clear full lines, count them and flag game over.
module board_engine #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int XW      = 4,
  parameter int YW      = 5,
  parameter int LINES_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_board,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic                       op_lock,
  input  logic [4*XW-1:0]            cell_x,
  input  logic [4*YW-1:0]            cell_y,
  output logic                       resp_valid,
  output logic                       resp_hit,
  output logic                       lock_done,
  output logic [2:0]                 lock_lines,
  output logic [LINES_W-1:0]         lines_total,
  output logic                       game_over,
  output logic [BOARD_W*BOARD_H-1:0] board
);

  localparam int NB = BOARD_W * BOARD_H;
  localparam int IW = $clog2(NB);

  typedef enum logic [2:0] {IDLE, RESP, WRITE, SCAN, DONE} state_t;

  state_t               state, state_nxt;
  logic [NB-1:0]        board_q;
  logic                 hit_q;
  logic [3:0][IW-1:0]   idx_q;
  logic [YW-1:0]        row_q;
  logic [2:0]           count_q;
  logic [2:0]           lock_lines_q;
  logic [LINES_W-1:0]   lines_total_q;
  logic                 game_over_q;

  logic [3:0][XW-1:0]   cx;
  logic [3:0][YW-1:0]   cy;
  logic [3:0]           oob;
  logic [3:0]           cell_hit;
  logic [3:0][IW-1:0]   idx;
  logic                 hit;
  logic                 accept;
  logic                 row_full;
  logic [NB-1:0]        board_shl;
  logic [NB-1:0]        shifted;
  logic [LINES_W:0]     lines_sum;

  assign cx          = cell_x;
  assign cy          = cell_y;
  assign op_ready    = (state == IDLE) && !game_over_q;
  assign accept      = op_valid && op_ready;
  assign resp_valid  = (state == RESP);
  assign resp_hit    = (state == RESP) && hit_q;
  assign lock_done   = (state == DONE);
  assign lock_lines  = lock_lines_q;
  assign lines_total = lines_total_q;
  assign game_over   = game_over_q;
  assign board       = board_q;

  // Collision test for the four candidate cells; off-board cells always hit,
  // which also keeps the board index below from being used out of range.
  always_comb begin
    oob      = '0;
    cell_hit = '0;
    idx      = '0;
    for (int i = 0; i < 4; i++) begin
      oob[i]      = (cx[i] >= XW'(BOARD_W)) || (cy[i] >= YW'(BOARD_H));
      idx[i]      = IW'(cy[i]) * IW'(BOARD_W) + IW'(cx[i]);
      cell_hit[i] = oob[i] ? 1'b1 : board_q[idx[i]];
    end
    hit = |cell_hit;
  end

  // Row under the scan pointer: fullness, and the board with rows 0..r
  // pulled down one row (row 0 refilled with zeros by the shift).
  always_comb begin
    row_full  = 1'b0;
    board_shl = board_q << BOARD_W;
    shifted   = board_q;
    for (int y = 0; y < BOARD_H; y++) begin
      if (YW'(y) == row_q)
        row_full = &board_q[y*BOARD_W +: BOARD_W];
      if (YW'(y) <= row_q)
        shifted[y*BOARD_W +: BOARD_W] = board_shl[y*BOARD_W +: BOARD_W];
    end
  end

  assign lines_sum = {1'b0, lines_total_q} + (LINES_W+1)'(lock_lines_q);

  // State register; rst and clear_board both force IDLE.
  always_ff @(posedge clk) begin
    if (rst || clear_board) state <= IDLE;
    else                    state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = op_lock ? WRITE : RESP;
      RESP:  state_nxt = IDLE;
      WRITE: state_nxt = hit_q ? DONE : SCAN;
      SCAN:  if (!row_full && row_q == '0) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: query capture, piece write, line-clear scan, totals.
  always_ff @(posedge clk) begin
    if (rst || clear_board) begin
      board_q       <= '0;
      hit_q         <= 1'b0;
      idx_q         <= '0;
      row_q         <= '0;
      count_q       <= '0;
      lock_lines_q  <= '0;
      lines_total_q <= '0;
      game_over_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          hit_q <= hit;
          idx_q <= idx;
        end
        WRITE: begin
          if (hit_q) begin
            game_over_q  <= 1'b1;
            lock_lines_q <= '0;
          end else begin
            for (int i = 0; i < 4; i++) board_q[idx_q[i]] <= 1'b1;
            row_q   <= YW'(BOARD_H - 1);
            count_q <= '0;
          end
        end
        SCAN: begin
          // A full row is collapsed and the same row index is re-examined,
          // since it now holds what used to sit above it.
          if (row_full) begin
            board_q <= shifted;
            count_q <= count_q + 3'd1;
          end else if (row_q == '0) begin
            lock_lines_q <= count_q;
          end else begin
            row_q <= row_q - 1'b1;
          end
        end
        DONE: lines_total_q <= lines_sum[LINES_W] ? '1 : lines_sum[LINES_W-1:0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_engine.sv
// Directed bench for board_engine with default geometry (10 x 20).
module tb_board_engine;

  logic         clk = 1'b0;
  logic         rst, clear_board, op_valid, op_lock;
  logic         op_ready, resp_valid, resp_hit, lock_done, game_over;
  logic [15:0]  cell_x;
  logic [19:0]  cell_y;
  logic [2:0]   lock_lines;
  logic [15:0]  lines_total;
  logic [199:0] board;

  int n_assert = 0;
  int n_fail   = 0;

  logic [199:0] exp_b;

  board_engine dut (
    .clk(clk), .rst(rst), .clear_board(clear_board),
    .op_valid(op_valid), .op_ready(op_ready), .op_lock(op_lock),
    .cell_x(cell_x), .cell_y(cell_y),
    .resp_valid(resp_valid), .resp_hit(resp_hit),
    .lock_done(lock_done), .lock_lines(lock_lines),
    .lines_total(lines_total), .game_over(game_over), .board(board)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] px(input int a, input int b, input int c, input int d);
    return {4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  function automatic logic [19:0] py(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic int bi(input int x, input int y);
    return y * 10 + x;
  endfunction

  // CHECK: accepted at one edge, resp_valid must be seen at the next.
  task automatic do_check(input logic [15:0] cx, input logic [19:0] cy,
                          input logic exp_hit, input string tag);
    @(negedge clk);
    cell_x = cx; cell_y = cy; op_lock = 1'b0; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_valid"}, 256'(resp_valid), 256'(1'b1));
    chk({tag, "_hit"},   256'(resp_hit),   256'(exp_hit));
  endtask

  // LOCK: returns at the mid-cycle point where lock_done is high.
  task automatic do_lock(input logic [15:0] cx, input logic [19:0] cy,
                         input int exp_lat, input logic [2:0] exp_lines, input string tag);
    int lat;
    @(negedge clk);
    cell_x = cx; cell_y = cy; op_lock = 1'b1; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (lock_done) begin lat = k; break; end
    end
    chk({tag, "_lat"},   256'(lat),        256'(exp_lat));
    chk({tag, "_lines"}, 256'(lock_lines), 256'(exp_lines));
  endtask

  task automatic pulse_clear(input logic r, input logic c);
    @(negedge clk);
    rst = r; clear_board = c;
    @(posedge clk); #1;
    rst = 1'b0; clear_board = 1'b0;
  endtask

  initial begin
    logic [15:0] cx;
    logic [19:0] cy;
    int seen;
    rst = 1'b1; clear_board = 1'b0; op_valid = 1'b0; op_lock = 1'b0;
    cell_x = '0; cell_y = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_board",  256'(board),       256'(0));
    chk("rst_ready",  256'(op_ready),    256'(1));
    chk("rst_lines",  256'(lines_total), 256'(0));
    chk("rst_gover",  256'(game_over),   256'(0));
    chk("rst_resp",   256'(resp_valid),  256'(0));
    chk("rst_done",   256'(lock_done),   256'(0));
    chk("rst_llines", 256'(lock_lines),  256'(0));

    // Collision queries on an empty board, including range edges.
    do_check(px(0,1,2,3),   py(0,0,0,0),     1'b0, "chk_top");
    do_check(px(0,1,2,10),  py(0,0,0,0),     1'b1, "chk_x10");
    do_check(px(0,1,2,3),   py(0,0,0,20),    1'b1, "chk_y20");
    do_check(px(9,9,9,9),   py(19,19,19,19), 1'b0, "chk_corner");
    do_check(px(15,0,0,0),  py(0,0,0,0),     1'b1, "chk_x15");

    // Single line clear with shift of the row above.
    do_lock(px(0,1,2,3), py(19,19,19,19), 22, 3'd0, "lk_pre1");
    do_lock(px(4,5,0,0), py(19,19,18,18), 22, 3'd0, "lk_pre2");
    do_lock(px(6,7,8,9), py(19,19,19,19), 23, 3'd1, "lk_one");
    @(negedge clk);
    exp_b = '0; exp_b[bi(0,19)] = 1'b1;
    chk("one_board", 256'(board),       256'(exp_b));
    chk("one_total", 256'(lines_total), 256'(1));
    do_check(px(0,0,0,0), py(19,19,19,19), 1'b1, "chk_occ");

    // Four-line clear with a vertical I piece.
    pulse_clear(1'b0, 1'b1);
    chk("clr_total", 256'(lines_total), 256'(0));
    for (int k = 0; k < 36; k += 4) begin
      for (int j = 0; j < 4; j++) begin
        cx[j*4 +: 4] = 4'((k + j) % 9);
        cy[j*5 +: 5] = 5'(16 + (k + j) / 9);
      end
      do_lock(cx, cy, 22, 3'd0, "lk_fill4");
    end
    do_lock(px(9,9,9,9), py(16,17,18,19), 26, 3'd4, "lk_four");
    @(negedge clk);
    chk("four_board", 256'(board),       256'(0));
    chk("four_total", 256'(lines_total), 256'(4));

    // Non-contiguous clears of rows 17 and 19.
    for (int k = 0; k < 20; k += 4) begin
      for (int j = 0; j < 4; j++) begin
        int n;
        n = k + j;
        if (n < 9)       begin cx[j*4 +: 4] = 4'(n);     cy[j*5 +: 5] = 5'd17; end
        else if (n < 18) begin cx[j*4 +: 4] = 4'(n - 9); cy[j*5 +: 5] = 5'd19; end
        else if (n == 18) begin cx[j*4 +: 4] = 4'd3;     cy[j*5 +: 5] = 5'd18; end
        else             begin cx[j*4 +: 4] = 4'd5;      cy[j*5 +: 5] = 5'd16; end
      end
      do_lock(cx, cy, 22, 3'd0, "lk_fill2");
    end
    do_lock(px(9,9,9,9), py(17,19,17,19), 24, 3'd2, "lk_two");
    @(negedge clk);
    exp_b = '0; exp_b[bi(3,19)] = 1'b1; exp_b[bi(5,18)] = 1'b1;
    chk("two_board", 256'(board),       256'(exp_b));
    chk("two_total", 256'(lines_total), 256'(6));

    // Colliding LOCK ends the game.
    do_lock(px(3,0,1,2), py(19,0,0,0), 2, 3'd0, "lk_coll");
    @(negedge clk);
    chk("coll_board", 256'(board),     256'(exp_b));
    chk("coll_gover", 256'(game_over), 256'(1));
    chk("coll_ready", 256'(op_ready),  256'(0));
    cell_x = px(0,1,2,3); cell_y = py(0,0,0,0); op_lock = 1'b0; op_valid = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid || lock_done) seen++;
    end
    op_valid = 1'b0;
    chk("coll_ignored", 256'(seen),        256'(0));
    chk("coll_total",   256'(lines_total), 256'(6));
    pulse_clear(1'b0, 1'b1);
    @(negedge clk);
    chk("restart_gover", 256'(game_over),   256'(0));
    chk("restart_board", 256'(board),       256'(0));
    chk("restart_ready", 256'(op_ready),    256'(1));
    chk("restart_total", 256'(lines_total), 256'(0));

    // clear_board aborts a scan in flight.
    @(negedge clk);
    cell_x = px(0,1,2,3); cell_y = py(5,5,5,5); op_lock = 1'b1; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy", 256'(op_ready), 256'(0));
    pulse_clear(1'b0, 1'b1);
    chk("mid_ready", 256'(op_ready),    256'(1));
    chk("mid_board", 256'(board),       256'(0));
    chk("mid_total", 256'(lines_total), 256'(0));
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (lock_done) seen++;
    end
    chk("mid_nodone", 256'(seen), 256'(0));

    // rst together with clear_board.
    do_lock(px(0,1,2,3), py(0,0,0,0), 22, 3'd0, "lk_prers");
    @(negedge clk);
    chk("prers_board", 256'(board != 200'd0), 256'(1));
    pulse_clear(1'b1, 1'b1);
    chk("both_board", 256'(board),      256'(0));
    chk("both_ready", 256'(op_ready),   256'(1));
    chk("both_gover", 256'(game_over),  256'(0));
    chk("both_llines", 256'(lock_lines), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
